pixel_loader: RTL



---
 rtl/matrix_pkg.sv | 20 ++
 rtl/strobe_sync.sv | 28 ++
 rtl/pixel_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the HUB75 matrix pipeline.
// Word layout: [31] frame start, [30:24] reserved, [23:0] RGB888.
package matrix_pkg;

  localparam int PANEL_WIDTH  = 64;
  localparam int PANEL_HEIGHT = 32;
  localparam int FB_ADDR_BITS = 11;

  localparam int FRAME_START_BIT = 31;
  localparam int RSVD_MSB        = 30;
  localparam int RSVD_LSB        = 24;
  localparam int RGB_MSB         = 23;
  localparam int RGB_LSB         = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// o_rise is a single clk-cycle pulse per rising edge of i_async.
module strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pixel_loader.sv
// SPI word to double-buffered framebuffer loader.
// Writes the back bank and swaps banks when a full frame lands.
module pixel_loader
  import matrix_pkg::*;
#(
  parameter int WIDTH     = PANEL_WIDTH,
  parameter int HEIGHT    = PANEL_HEIGHT,
  parameter int ADDR_BITS = FB_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          spi_data,
  input  logic                 spi_word_strobe,
  output logic                 fb_write_en,
  output logic [ADDR_BITS:0]   fb_write_addr,
  output logic [23:0]          fb_write_data,
  output logic                 display_bank,
  output logic                 frame_done,
  output logic                 sync_error
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX =
    ADDR_BITS'(WIDTH * HEIGHT - 1);

  logic                 w_word_valid;
  logic [31:0]          r_hold;
  logic                 r_hold_vld;
  logic                 w_unused_rsvd;

  ld_state_t            r_state;
  ld_state_t            w_state_nx;
  logic [ADDR_BITS-1:0] r_idx;
  logic [ADDR_BITS-1:0] w_idx_nx;
  logic [ADDR_BITS-1:0] w_pos;

  logic                 w_fs;
  logic                 w_drop;
  logic                 w_write;
  logic                 w_we_nx;
  logic [ADDR_BITS:0]   w_addr_nx;
  logic [23:0]          w_data_nx;
  logic                 w_bank_nx;
  logic                 w_done_nx;
  logic                 w_err_nx;

  strobe_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (spi_word_strobe),
    .o_rise  (w_word_valid)
  );

  // spi_data is stable for several clk cycles after the strobe rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_hold_vld <= w_word_valid;
      if (w_word_valid) begin
        r_hold <= spi_data;
      end
    end
  end

  assign w_unused_rsvd = ^r_hold[RSVD_MSB:RSVD_LSB];

  assign w_fs    = r_hold[FRAME_START_BIT];
  assign w_pos   = w_fs ? '0 : r_idx;
  assign w_drop  = r_hold_vld & ~w_fs & (r_state == ST_IDLE);
  assign w_write = r_hold_vld & ~w_drop;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_we_nx    = 1'b0;
    w_addr_nx  = fb_write_addr;
    w_data_nx  = fb_write_data;
    w_bank_nx  = display_bank;
    w_done_nx  = 1'b0;
    w_err_nx   = sync_error;

    unique case (1'b1)
      w_drop: begin
        w_err_nx = 1'b1;
      end
      w_write: begin
        w_we_nx   = 1'b1;
        w_addr_nx = {~display_bank, w_pos};
        w_data_nx = r_hold[RGB_MSB:RGB_LSB];
        if (w_fs && (r_state == ST_LOAD)) begin
          w_err_nx = 1'b1;
        end
        if (w_pos == LAST_IDX) begin
          w_bank_nx  = ~display_bank;
          w_done_nx  = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_idx_nx   = w_pos + 1'b1;
          w_state_nx = ST_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      fb_write_en   <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
      display_bank  <= 1'b0;
      frame_done    <= 1'b0;
      sync_error    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_idx         <= w_idx_nx;
      fb_write_en   <= w_we_nx;
      fb_write_addr <= w_addr_nx;
      fb_write_data <= w_data_nx;
      display_bank  <= w_bank_nx;
      frame_done    <= w_done_nx;
      sync_error    <= w_err_nx;
    end
  end

endmodule
